// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache.
// Contents: FSM state type, address-field widths and the line-address helper.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } dcache_state_t;

  localparam int OFFSET_W   = 6;    // byte offset inside a 64-byte line
  localparam int WORD_SEL_W = 3;    // byte offset inside a 64-bit word
  localparam int LINE_W     = 512;  // line width in bits

  // Base address of the line containing addr.
  function automatic logic [63:0] line_addr(input logic [63:0] addr);
    return {addr[63:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Bus bundles for the L1 data cache.
// dcache_core_if : core MEM stage <-> cache (master = core, slave = cache)
//   enable, wenable, addr, wdata  core -> cache request
//   rdata, done                   cache -> core response
// dcache_mem_if  : cache <-> memory arbiter (master = cache, slave = arbiter)
//   drequest, dwrenable, daddr, dwdata  cache -> arbiter line transfer request
//   drdata, ddone                       arbiter -> cache fill data / completion
interface dcache_core_if;
  logic        enable;
  logic        wenable;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        done;

  modport master (output enable, wenable, addr, wdata, input rdata, done);
  modport slave  (input enable, wenable, addr, wdata, output rdata, done);
endinterface

interface dcache_mem_if;
  logic         drequest;
  logic         dwrenable;
  logic [63:0]  daddr;
  logic [511:0] dwdata;
  logic [511:0] drdata;
  logic         ddone;

  modport master (output drequest, dwrenable, daddr, dwdata, input drdata, ddone);
  modport slave  (input drequest, dwrenable, daddr, dwdata, output drdata, ddone);
endinterface

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped data cache: valid, dirty, tag and data
// per set. One combinational read port, one write port updated on posedge clk.
// A write always marks the line valid. Valid/dirty clear on synchronous reset.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   rd_idx_i          read set index
//   rd_valid_o .. rd_data_o  contents of the addressed set
//   wr_en_i, wr_idx_i write strobe and set index
//   wr_dirty_i, wr_tag_i, wr_data_i  new line state
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  parameter int TAG_W    = 64 - OFFSET_W - INDEX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               wr_dirty_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Tag/data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/data_cache.sv
// L1 data cache: direct-mapped, write-back, write-allocate, 64-byte lines,
// one outstanding core request. Sits between the core MEM stage and the
// memory arbiter data port.
// Ports:
//   clk      single clock
//   reset    synchronous reset, active-low
//   core_if  core request/response bundle (slave side)
//   mem_if   arbiter line-transfer bundle (master side)
//
// state | meaning
// IDLE  | waiting for a request; lookup happens in the accept cycle
// WB    | writing the dirty victim line back, outputs held until ddone
// FILL  | fetching the requested line, installed on ddone
// RESP  | done pulse, rdata valid for loads
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 64
) (
  input logic          clk,
  input logic          reset,
  dcache_core_if.slave core_if,
  dcache_mem_if.master mem_if
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 64 - OFFSET_W - INDEX_W;

  dcache_state_t           state_q;
  logic [63:WORD_SEL_W]    addr_q;
  logic                    we_q;
  logic [63:0]             wdata_q;
  logic                    done_q;
  logic [63:0]             rdata_q;
  logic                    drequest_q;
  logic                    dwrenable_q;
  logic [63:0]             daddr_q;
  logic [LINE_W-1:0]       dwdata_q;

  logic                    rd_valid;
  logic                    rd_dirty;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_W-1:0]       rd_data;
  logic                    wr_en;
  logic                    wr_dirty;
  logic [TAG_W-1:0]        wr_tag;
  logic [LINE_W-1:0]       wr_data;

  logic [63:WORD_SEL_W]    cur_addr;
  logic [2:0]              cur_off;
  logic [INDEX_W-1:0]      cur_idx;
  logic [TAG_W-1:0]        cur_tag;
  logic                    hit;
  logic                    accept;
  logic [63:0]             hit_word;
  logic [63:0]             fill_word;
  logic                    unused_addr_bits;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0]        off,
                                                   input logic [63:0]       word);
    logic [LINE_W-1:0] m;
    m = line;
    m[{off, 6'b0} +: 64] = word;
    return m;
  endfunction

  // In IDLE the lookup uses the live request address; afterwards the latched one.
  assign cur_addr  = (state_q == IDLE) ? core_if.addr[63:WORD_SEL_W] : addr_q;
  assign cur_off   = cur_addr[OFFSET_W-1:WORD_SEL_W];
  assign cur_idx   = cur_addr[OFFSET_W +: INDEX_W];
  assign cur_tag   = cur_addr[63 -: TAG_W];
  assign hit       = rd_valid && (rd_tag == cur_tag);
  assign accept    = (state_q == IDLE) && core_if.enable && !done_q;
  assign hit_word  = rd_data[{cur_off, 6'b0} +: 64];
  assign fill_word = mem_if.drdata[{cur_off, 6'b0} +: 64];

  assign unused_addr_bits = ^core_if.addr[WORD_SEL_W-1:0];

  dcache_array #(
    .NUM_SETS (NUM_SETS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (cur_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (cur_idx),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (wr_data)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_dirty = 1'b0;
    wr_tag   = rd_tag;
    wr_data  = rd_data;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (accept && hit && core_if.wenable) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = merge_word(rd_data, cur_off, core_if.wdata);
          end
        end
        WB: begin
          // Victim now matches memory: rewrite it unchanged but clean.
          if (mem_if.ddone) begin
            wr_en = 1'b1;
          end
        end
        FILL: begin
          if (drequest_q && mem_if.ddone) begin
            wr_en    = 1'b1;
            wr_tag   = cur_tag;
            wr_dirty = we_q;
            wr_data  = we_q ? merge_word(mem_if.drdata, cur_off, wdata_q) : mem_if.drdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      drequest_q  <= 1'b0;
      dwrenable_q <= 1'b0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= core_if.addr[63:WORD_SEL_W];
            we_q    <= core_if.wenable;
            wdata_q <= core_if.wdata;
            if (hit) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              if (!core_if.wenable) begin
                rdata_q <= hit_word;
              end
            end else if (rd_valid && rd_dirty) begin
              state_q     <= WB;
              drequest_q  <= 1'b1;
              dwrenable_q <= 1'b1;
              daddr_q     <= {rd_tag, cur_idx, {OFFSET_W{1'b0}}};
              dwdata_q    <= rd_data;
            end else begin
              state_q     <= FILL;
              drequest_q  <= 1'b1;
              dwrenable_q <= 1'b0;
              daddr_q     <= line_addr(core_if.addr);
            end
          end
        end
        WB: begin
          // Drop drequest for one cycle so the fill is a fresh request,
          // never overlapping the write-back's ddone.
          if (mem_if.ddone) begin
            state_q     <= FILL;
            drequest_q  <= 1'b0;
            dwrenable_q <= 1'b0;
          end
        end
        FILL: begin
          if (!drequest_q) begin
            drequest_q <= 1'b1;
            daddr_q    <= line_addr({addr_q, {WORD_SEL_W{1'b0}}});
          end else if (mem_if.ddone) begin
            state_q    <= RESP;
            drequest_q <= 1'b0;
            done_q     <= 1'b1;
            if (!we_q) begin
              rdata_q <= fill_word;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_if.done     = done_q;
  assign core_if.rdata    = rdata_q;
  assign mem_if.drequest  = drequest_q;
  assign mem_if.dwrenable = dwrenable_q;
  assign mem_if.daddr     = daddr_q;
  assign mem_if.dwdata    = dwdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus a randomized run
// against a memory-level reference model (golden word memory + per-set tag
// bookkeeping) and an arbiter model with its own backing store.
module tb_data_cache;

  typedef struct {
    bit           we;
    logic [63:0]  addr;
    logic [511:0] data;
    int           done_cyc;
    bit           stable;
  } tx_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  dcache_core_if cif ();
  dcache_mem_if  mif ();

  data_cache #(.NUM_SETS(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .core_if (cif),
    .mem_if  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [63:0] gold    [logic [63:0]];  // word address -> current architectural value
  logic [63:0] arb_mem [logic [63:0]];  // word address -> value held by the arbiter
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [51:0] m_tag   [64];

  function automatic logic [63:0] mem_default(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:6], 6'b0};
    return base + {61'd0, a[5:3]};
  endfunction

  function automatic logic [63:0] gold_rd(input logic [63:0] a);
    if (gold.exists(a >> 3)) return gold[a >> 3];
    return mem_default(a);
  endfunction

  function automatic logic [63:0] arb_rd(input logic [63:0] a);
    if (arb_mem.exists(a >> 3)) return arb_mem[a >> 3];
    return mem_default(a);
  endfunction

  function automatic logic [511:0] gold_line(input logic [63:0] la);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = gold_rd(la + 64'(i * 8));
    return l;
  endfunction

  task automatic model_req(input bit we, input logic [63:0] a, input logic [63:0] wd,
                           output logic [63:0] er, output bit ehit, output bit ewb,
                           output logic [63:0] ewb_addr, output logic [511:0] ewb_line);
    int          s;
    logic [51:0] t;
    s = int'(a[11:6]);
    t = a[63:12];
    ehit     = m_valid[s] && (m_tag[s] == t);
    ewb      = !ehit && m_valid[s] && m_dirty[s];
    ewb_addr = {m_tag[s], a[11:6], 6'b0};
    ewb_line = gold_line(ewb_addr);
    if (!ehit) begin
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_dirty[s] = 1'b0;
    end
    if (we) begin
      gold[a >> 3] = wd;
      m_dirty[s]   = 1'b1;
    end
    er = gold_rd(a);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    gold = arb_mem;
  endtask

  // ---------------- arbiter model ----------------
  tx_t txlog[$];
  tx_t cur;
  bit  arb_pend;
  int  arb_cnt;
  int  arb_lat;
  bit  stray_req;

  initial begin
    logic [511:0] line;
    mif.ddone  = 1'b0;
    mif.drdata = '0;
    arb_pend   = 1'b0;
    arb_cnt    = 0;
    forever begin
      @(negedge clk);
      mif.ddone = 1'b0;
      if (!reset) begin
        arb_pend = 1'b0;
      end else if (stray_req) begin
        mif.ddone  = 1'b1;
        mif.drdata = {8{64'hBAD0_BAD0_BAD0_BAD0}};
        stray_req  = 1'b0;
      end else if (arb_pend) begin
        if (mif.drequest !== 1'b1 || mif.dwrenable !== cur.we || mif.daddr !== cur.addr ||
            (cur.we && mif.dwdata !== cur.data))
          cur.stable = 1'b0;
        arb_cnt--;
        if (arb_cnt <= 0) begin
          if (cur.we) begin
            for (int i = 0; i < 8; i++) arb_mem[(cur.addr >> 3) + 64'(i)] = cur.data[i*64 +: 64];
          end else begin
            for (int i = 0; i < 8; i++) line[i*64 +: 64] = arb_rd(cur.addr + 64'(i * 8));
            mif.drdata = line;
            cur.data   = line;
          end
          mif.ddone    = 1'b1;
          cur.done_cyc = cyc;
          txlog.push_back(cur);
          arb_pend = 1'b0;
        end
      end else if (mif.drequest === 1'b1) begin
        cur.we       = mif.dwrenable;
        cur.addr     = mif.daddr;
        cur.data     = mif.dwdata;
        cur.stable   = 1'b1;
        cur.done_cyc = 0;
        arb_cnt      = arb_lat;
        arb_pend     = 1'b1;
      end
    end
  end

  // ---------------- core driver ----------------
  task automatic do_req(input bit we, input logic [63:0] a, input logic [63:0] wd, input bit hold,
                        output logic [63:0] rd, output int dcyc, output int lat,
                        output bit ok, output int extra);
    int start;
    @(negedge clk);
    cif.enable  = 1'b1;
    cif.wenable = we;
    cif.addr    = a;
    cif.wdata   = wd;
    start = cyc; ok = 1'b0; lat = 0; dcyc = 0; rd = '0; extra = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cif.done === 1'b1) begin
        ok = 1'b1; dcyc = cyc; lat = cyc - start; rd = cif.rdata;
        break;
      end
    end
    if (!hold) cif.enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cif.enable = 1'b0;
      if (cif.done === 1'b1) extra++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cif.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", cif.done); end
    n_checks++; if (mif.drequest !== 1'b0) begin n_errors++; $display("FAIL reset_drequest: got %b want 0", mif.drequest); end
    n_checks++; if (mif.dwrenable !== 1'b0) begin n_errors++; $display("FAIL reset_dwrenable: got %b want 0", mif.dwrenable); end
    n_checks++; if (mif.daddr !== 64'h0) begin n_errors++; $display("FAIL reset_daddr: got %h want 0", mif.daddr); end
    n_checks++; if (mif.dwdata !== 512'h0) begin n_errors++; $display("FAIL reset_dwdata: got nonzero want 0"); end
    n_checks++; if (cif.rdata !== 64'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", cif.rdata); end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_miss();
    logic [63:0] er, rd, wa; logic [511:0] wl; bit eh, ewb, ok; int dc, lat, extra;
    model_req(1'b0, 64'h1008, 64'h0, er, eh, ewb, wa, wl);
    txlog.delete(); arb_lat = 3;
    do_req(1'b0, 64'h1008, 64'h0, 1'b0, rd, dc, lat, ok, extra);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL cold_done: got timeout want done"); end
    n_checks++; if (txlog.size() != 1) begin n_errors++; $display("FAIL cold_ntx: got %0d want 1", txlog.size()); end
    if (txlog.size() >= 1) begin
      n_checks++; if (txlog[0].we !== 1'b0 || txlog[0].addr !== 64'h1000) begin n_errors++;
        $display("FAIL cold_fill: got we=%b addr=%h want we=0 addr=1000", txlog[0].we, txlog[0].addr); end
      n_checks++; if (dc != txlog[0].done_cyc + 1) begin n_errors++;
        $display("FAIL cold_latency: got done cycle %0d want %0d", dc, txlog[0].done_cyc + 1); end
    end
    n_checks++; if (rd !== 64'h1001) begin n_errors++; $display("FAIL cold_rdata: got %h want 1001", rd); end
    n_checks++; if (extra != 0) begin n_errors++; $display("FAIL cold_single_done: got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_load_hit();
    logic [63:0] er, rd, wa; logic [511:0] wl; bit eh, ewb, ok; int dc, lat, extra;
    model_req(1'b0, 64'h1008, 64'h0, er, eh, ewb, wa, wl);
    txlog.delete();
    // enable kept high through the done cycle: must not be re-accepted
    do_req(1'b0, 64'h1008, 64'h0, 1'b1, rd, dc, lat, ok, extra);
    n_checks++; if (!ok || lat != 1) begin n_errors++; $display("FAIL hit_latency: got ok=%b lat=%0d want lat=1", ok, lat); end
    n_checks++; if (txlog.size() != 0 || arb_pend) begin n_errors++; $display("FAIL hit_no_drequest: got %0d transfers want 0", txlog.size()); end
    n_checks++; if (rd !== 64'h1001) begin n_errors++; $display("FAIL hit_rdata: got %h want 1001", rd); end
    n_checks++; if (extra != 0) begin n_errors++; $display("FAIL hit_no_reaccept: got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_store_hit();
    logic [63:0] er, rd, wa; logic [511:0] wl; bit eh, ewb, ok; int dc, lat, extra;
    model_req(1'b1, 64'h1010, 64'hDEADBEEF, er, eh, ewb, wa, wl);
    txlog.delete();
    do_req(1'b1, 64'h1010, 64'hDEADBEEF, 1'b0, rd, dc, lat, ok, extra);
    n_checks++; if (!ok || lat != 1) begin n_errors++; $display("FAIL store_hit_latency: got ok=%b lat=%0d want lat=1", ok, lat); end
    model_req(1'b0, 64'h1010, 64'h0, er, eh, ewb, wa, wl);
    do_req(1'b0, 64'h1010, 64'h0, 1'b0, rd, dc, lat, ok, extra);
    n_checks++; if (!ok || lat != 1) begin n_errors++; $display("FAIL store_load_latency: got ok=%b lat=%0d want lat=1", ok, lat); end
    n_checks++; if (rd !== 64'hDEADBEEF) begin n_errors++; $display("FAIL store_load_rdata: got %h want deadbeef", rd); end
    n_checks++; if (txlog.size() != 0) begin n_errors++; $display("FAIL store_no_drequest: got %0d transfers want 0", txlog.size()); end
  endtask

  task automatic test_dirty_conflict();
    logic [63:0] er, rd, wa; logic [511:0] wl; bit eh, ewb, ok; int dc, lat, extra;
    model_req(1'b0, 64'h2010, 64'h0, er, eh, ewb, wa, wl);
    txlog.delete(); arb_lat = 2;
    do_req(1'b0, 64'h2010, 64'h0, 1'b0, rd, dc, lat, ok, extra);
    n_checks++; if (txlog.size() != 2) begin n_errors++; $display("FAIL conflict_ntx: got %0d want 2", txlog.size()); end
    if (txlog.size() == 2) begin
      n_checks++; if (txlog[0].we !== 1'b1 || txlog[0].addr !== 64'h1000) begin n_errors++;
        $display("FAIL conflict_wb: got we=%b addr=%h want we=1 addr=1000", txlog[0].we, txlog[0].addr); end
      n_checks++; if (txlog[0].data[191:128] !== 64'hDEADBEEF) begin n_errors++;
        $display("FAIL conflict_wb_data: got %h want deadbeef", txlog[0].data[191:128]); end
      n_checks++; if (!txlog[0].stable) begin n_errors++; $display("FAIL conflict_wb_stable: got changing outputs want held"); end
      n_checks++; if (txlog[1].we !== 1'b0 || txlog[1].addr !== 64'h2000) begin n_errors++;
        $display("FAIL conflict_fill: got we=%b addr=%h want we=0 addr=2000", txlog[1].we, txlog[1].addr); end
      n_checks++; if (dc != txlog[1].done_cyc + 1) begin n_errors++;
        $display("FAIL conflict_latency: got done cycle %0d want %0d", dc, txlog[1].done_cyc + 1); end
    end
    n_checks++; if (rd !== 64'h2002) begin n_errors++; $display("FAIL conflict_rdata: got %h want 2002", rd); end
  endtask

  task automatic test_store_miss();
    logic [63:0] er, rd, wa; logic [511:0] wl; bit eh, ewb, ok; int dc, lat, extra;
    model_req(1'b1, 64'h3000, 64'h55, er, eh, ewb, wa, wl);
    txlog.delete(); arb_lat = 1;
    do_req(1'b1, 64'h3000, 64'h55, 1'b0, rd, dc, lat, ok, extra);
    n_checks++; if (txlog.size() != 1) begin n_errors++; $display("FAIL smiss_ntx: got %0d want 1", txlog.size()); end
    if (txlog.size() == 1) begin
      n_checks++; if (txlog[0].we !== 1'b0 || txlog[0].addr !== 64'h3000) begin n_errors++;
        $display("FAIL smiss_fill: got we=%b addr=%h want we=0 addr=3000", txlog[0].we, txlog[0].addr); end
    end
    model_req(1'b0, 64'h3000, 64'h0, er, eh, ewb, wa, wl);
    txlog.delete();
    do_req(1'b0, 64'h3000, 64'h0, 1'b0, rd, dc, lat, ok, extra);
    n_checks++; if (!ok || lat != 1 || txlog.size() != 0) begin n_errors++;
      $display("FAIL smiss_reload_hit: got lat=%0d transfers=%0d want lat=1 transfers=0", lat, txlog.size()); end
    n_checks++; if (rd !== 64'h55) begin n_errors++; $display("FAIL smiss_reload_rdata: got %h want 55", rd); end
  endtask

  task automatic test_reset_mid_fill();
    logic [63:0] er, rd, wa; logic [511:0] wl; bit eh, ewb, ok, seen; int dc, lat, extra, ndone, nreq;
    txlog.delete(); arb_lat = 4; seen = 1'b0;
    @(negedge clk);
    cif.enable = 1'b1; cif.wenable = 1'b0; cif.addr = 64'h1048; cif.wdata = 64'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (mif.drequest === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL rmid_request: got no drequest want drequest"); end
    reset = 1'b0;
    cif.enable = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (mif.drequest !== 1'b0) begin n_errors++; $display("FAIL rmid_drequest: got %b want 0", mif.drequest); end
    n_checks++; if (cif.done !== 1'b0) begin n_errors++; $display("FAIL rmid_done: got %b want 0", cif.done); end
    @(negedge clk); #1;
    reset = 1'b1;
    model_reset();
    stray_req = 1'b1;
    ndone = 0; nreq = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (cif.done === 1'b1) ndone++;
      if (mif.drequest === 1'b1) nreq++;
    end
    n_checks++; if (ndone != 0 || nreq != 0 || txlog.size() != 0) begin n_errors++;
      $display("FAIL rmid_abandon: got done=%0d drequest=%0d transfers=%0d want 0/0/0", ndone, nreq, txlog.size()); end
    model_req(1'b0, 64'h1008, 64'h0, er, eh, ewb, wa, wl);
    arb_lat = 2;
    do_req(1'b0, 64'h1008, 64'h0, 1'b0, rd, dc, lat, ok, extra);
    n_checks++; if (txlog.size() != 1 || (txlog.size() == 1 && (txlog[0].we !== 1'b0 || txlog[0].addr !== 64'h1000))) begin
      n_errors++; $display("FAIL rmid_reload_miss: got %0d transfers want one fill of 1000", txlog.size()); end
    n_checks++; if (rd !== 64'h1001) begin n_errors++; $display("FAIL rmid_reload_rdata: got %h want 1001", rd); end
  endtask

  task automatic test_random();
    logic [63:0] er, rd, wa, a, wd; logic [511:0] wl; bit eh, ewb, ok, we; int dc, lat, extra, nexp;
    for (int n = 0; n < 200; n++) begin
      a  = (64'($urandom_range(1, 4)) << 12) | (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 7)) << 3);
      we = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      arb_lat = $urandom_range(1, 4);
      model_req(we, a, wd, er, eh, ewb, wa, wl);
      nexp = eh ? 0 : (ewb ? 2 : 1);
      txlog.delete();
      do_req(we, a, wd, 1'($urandom_range(0, 1)), rd, dc, lat, ok, extra);
      n_checks++; if (!ok || extra != 0) begin n_errors++;
        $display("FAIL rnd_done[%0d]: got ok=%b extra=%0d want ok=1 extra=0", n, ok, extra); end
      n_checks++; if (txlog.size() != nexp) begin n_errors++;
        $display("FAIL rnd_ntx[%0d] addr=%h: got %0d want %0d", n, a, txlog.size(), nexp); end
      if (eh) begin
        n_checks++; if (lat != 1) begin n_errors++; $display("FAIL rnd_hit_lat[%0d]: got %0d want 1", n, lat); end
      end else if (txlog.size() == nexp) begin
        if (ewb) begin
          n_checks++; if (txlog[0].we !== 1'b1 || txlog[0].addr !== wa || txlog[0].data !== wl || !txlog[0].stable) begin
            n_errors++; $display("FAIL rnd_wb[%0d]: got addr=%h want %h", n, txlog[0].addr, wa); end
        end
        n_checks++; if (txlog[nexp-1].we !== 1'b0 || txlog[nexp-1].addr !== {a[63:6], 6'b0}) begin
          n_errors++; $display("FAIL rnd_fill[%0d]: got addr=%h want %h", n, txlog[nexp-1].addr, {a[63:6], 6'b0}); end
        n_checks++; if (dc != txlog[nexp-1].done_cyc + 1) begin
          n_errors++; $display("FAIL rnd_miss_lat[%0d]: got %0d want %0d", n, dc, txlog[nexp-1].done_cyc + 1); end
      end
      if (!we) begin
        n_checks++; if (rd !== er) begin n_errors++; $display("FAIL rnd_rdata[%0d] addr=%h: got %h want %h", n, a, rd, er); end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    reset = 1'b0; stray_req = 1'b0; arb_lat = 3;
    cif.enable = 1'b0; cif.wenable = 1'b0; cif.addr = '0; cif.wdata = '0;
    test_reset();
    test_cold_miss();
    test_load_hit();
    test_store_hit();
    test_dirty_conflict();
    test_store_miss();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
